// File: rtl/sort_seq_ip.sv
// Sequential odd-even transposition sorter: stable sort of IP_WIDTH elements by weight.
// Optional SORT_EARLY_EXIT_EN: finish once two consecutive phases make no swap.
module sort_seq_ip #(
    parameter int IP_WIDTH = 8,
    parameter int CHAR_W   = 4,
    parameter int WEIGHT_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         in_desc,
    input  logic [IP_WIDTH*CHAR_W-1:0]   in_character,
    input  logic [IP_WIDTH*WEIGHT_W-1:0] in_weight,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [IP_WIDTH*CHAR_W-1:0]   out_character,
    output logic [IP_WIDTH*WEIGHT_W-1:0] out_weight
);

    localparam int PW = $clog2(IP_WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SORT,
        DONE
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic [CHAR_W-1:0]   ch_q  [IP_WIDTH];
    logic [WEIGHT_W-1:0] wt_q  [IP_WIDTH];
    logic [CHAR_W-1:0]   ch_nx [IP_WIDTH];
    logic [WEIGHT_W-1:0] wt_nx [IP_WIDTH];
    logic                desc_q;
    logic [PW-1:0]       phase_q;
    logic                accept;
    logic                last_phase;

    assign in_ready   = (state == IDLE);
    assign out_valid  = (state == DONE);
    assign accept     = in_ready && in_valid;
    assign last_phase = (phase_q == PW'(IP_WIDTH - 1));

`ifdef SORT_EARLY_EXIT_EN
    logic any_swap;
    logic quiet_q;
`endif

    // One transposition phase: disjoint adjacent pairs chosen by phase parity
    always_comb begin
        for (int i = 0; i < IP_WIDTH; i++) begin
            ch_nx[i] = ch_q[i];
            wt_nx[i] = wt_q[i];
        end
`ifdef SORT_EARLY_EXIT_EN
        any_swap = 1'b0;
`endif
        for (int i = 0; i < IP_WIDTH - 1; i++) begin
            if (1'(i) == phase_q[0]) begin
                if (desc_q ? (wt_q[i] < wt_q[i+1])
                           : (wt_q[i] > wt_q[i+1])) begin
                    ch_nx[i]   = ch_q[i+1];
                    ch_nx[i+1] = ch_q[i];
                    wt_nx[i]   = wt_q[i+1];
                    wt_nx[i+1] = wt_q[i];
`ifdef SORT_EARLY_EXIT_EN
                    any_swap   = 1'b1;
`endif
                end
            end
        end
    end

    // Next-state decode for the job lifecycle
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (in_valid) state_nx = SORT;
            end
            SORT: begin
                if (last_phase) state_nx = DONE;
`ifdef SORT_EARLY_EXIT_EN
                else if (!any_swap && quiet_q) state_nx = DONE;
`endif
            end
            DONE: begin
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // Element registers, stored mode and phase counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < IP_WIDTH; i++) begin
                ch_q[i] <= '0;
                wt_q[i] <= '0;
            end
            desc_q  <= 1'b0;
            phase_q <= '0;
        end else if (accept) begin
            for (int i = 0; i < IP_WIDTH; i++) begin
                ch_q[i] <= in_character[i*CHAR_W +: CHAR_W];
                wt_q[i] <= in_weight[i*WEIGHT_W +: WEIGHT_W];
            end
            desc_q  <= in_desc;
            phase_q <= '0;
        end else if (state == SORT) begin
            for (int i = 0; i < IP_WIDTH; i++) begin
                ch_q[i] <= ch_nx[i];
                wt_q[i] <= wt_nx[i];
            end
            phase_q <= phase_q + 1'b1;
        end
    end

`ifdef SORT_EARLY_EXIT_EN
    // Remembers whether the previous phase was swap-free
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 quiet_q <= 1'b0;
        else if (accept)         quiet_q <= 1'b0;
        else if (state == SORT)  quiet_q <= !any_swap;
    end
`endif

    for (genvar g = 0; g < IP_WIDTH; g++) begin : g_out
        assign out_character[g*CHAR_W +: CHAR_W]   = ch_q[g];
        assign out_weight[g*WEIGHT_W +: WEIGHT_W]  = wt_q[g];
    end

endmodule

// File: tb/tb_sort_seq_ip.sv
// Directed bench for sort_seq_ip with a stable insertion-sort reference model.
// Latency expectations adapt when SORT_EARLY_EXIT_EN is defined.
module tb_sort_seq_ip;

    localparam int N  = 8;
    localparam int CW = 4;
    localparam int WW = 5;
`ifdef SORT_EARLY_EXIT_EN
    localparam int MIX_LAT = 0;
    localparam int EQ_LAT  = 2;
`else
    localparam int MIX_LAT = N;
    localparam int EQ_LAT  = N;
`endif

    logic            clk = 1'b0;
    logic            rst;
    logic            in_valid;
    logic            in_ready;
    logic            in_desc;
    logic [N*CW-1:0] in_character;
    logic [N*WW-1:0] in_weight;
    logic            out_valid;
    logic            out_ready;
    logic [N*CW-1:0] out_character;
    logic [N*WW-1:0] out_weight;

    int checks = 0;
    int errors = 0;

    logic [N*CW-1:0] exp_c;
    logic [N*WW-1:0] exp_w;
    bit              model_valid = 1'b0;

    sort_seq_ip #(.IP_WIDTH(N), .CHAR_W(CW), .WEIGHT_W(WW)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_desc(in_desc),
        .in_character(in_character),
        .in_weight(in_weight),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_character(out_character),
        .out_weight(out_weight)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    function automatic logic [N*WW-1:0] pack_w(input int a[N]);
        logic [N*WW-1:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*WW +: WW] = WW'(a[i]);
        return r;
    endfunction

    // Stable sort by weight; characters ride along
    function automatic void model_sort(input logic [N*CW-1:0] c,
                                       input logic [N*WW-1:0] w,
                                       input bit desc,
                                       output logic [N*CW-1:0] oc,
                                       output logic [N*WW-1:0] ow);
        int kc[N];
        int kw[N];
        int t;
        for (int i = 0; i < N; i++) begin
            kc[i] = int'(c[i*CW +: CW]);
            kw[i] = int'(w[i*WW +: WW]);
        end
        for (int i = 1; i < N; i++) begin
            for (int j = i; j > 0; j--) begin
                if (desc ? (kw[j] > kw[j-1]) : (kw[j] < kw[j-1])) begin
                    t = kw[j]; kw[j] = kw[j-1]; kw[j-1] = t;
                    t = kc[j]; kc[j] = kc[j-1]; kc[j-1] = t;
                end else begin
                    break;
                end
            end
        end
        oc = '0;
        ow = '0;
        for (int i = 0; i < N; i++) begin
            oc[i*CW +: CW] = CW'(kc[i]);
            ow[i*WW +: WW] = WW'(kw[i]);
        end
    endfunction

    // Every valid result cycle must match the model
    always @(negedge clk) begin
        if (!rst && model_valid && out_valid) begin
            check("cmp_char", out_character, exp_c);
            check("cmp_weight", out_weight, exp_w);
            check("cmp_ready_low", in_ready, 1'b0);
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) check("ready_timeout", 1'b0, 1'b1);
    endtask

    task automatic wait_valid(input int lat, input string name);
        int n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        if (!out_valid) check({name, "_timeout"}, 1'b0, 1'b1);
        else if (lat > 0) check({name, "_latency"}, n, lat);
        else check({name, "_latency_max"}, n <= N, 1'b1);
    endtask

    task automatic run_job(input logic [N*CW-1:0] c,
                           input logic [N*WW-1:0] w,
                           input bit desc, input int lat,
                           input string name);
        wait_ready();
        in_character = c;
        in_weight    = w;
        in_desc      = desc;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        model_sort(c, w, desc, exp_c, exp_w);
        model_valid = 1'b1;
        wait_valid(lat, name);
    endtask

    task automatic release_out(input string name);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, "_idle_ready"}, in_ready, 1'b1);
        check({name, "_idle_valid"}, out_valid, 1'b0);
        check({name, "_idle_hold"}, out_character, exp_c);
    endtask

    initial begin
        int wa[N];
        logic [N*CW-1:0] c0;
        logic [N*WW-1:0] w0;
        logic [N*WW-1:0] wrev;

        rst = 1'b1;
        in_valid = 1'b0;
        in_desc = 1'b0;
        in_character = '0;
        in_weight = '0;
        out_ready = 1'b0;
        c0 = 32'h76543210;
        wa = '{5, 3, 5, 1, 9, 0, 3, 31};
        w0 = pack_w(wa);
        wa = '{7, 6, 5, 4, 3, 2, 1, 0};
        wrev = pack_w(wa);

        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", in_ready, 1'b1);
        check("rst_valid", out_valid, 1'b0);
        check("rst_char", out_character, '0);
        check("rst_weight", out_weight, '0);
        rst = 1'b0;
        @(posedge clk); #1;

        run_job(c0, w0, 1'b0, MIX_LAT, "asc");
        check("asc_char", out_character, 32'h74206135);
        wa = '{0, 1, 3, 3, 5, 5, 9, 31};
        check("asc_weight", out_weight, pack_w(wa));
        release_out("asc");

        run_job(c0, w0, 1'b1, MIX_LAT, "desc");
        check("desc_char", out_character, 32'h53612047);
        wa = '{31, 9, 5, 5, 3, 3, 1, 0};
        check("desc_weight", out_weight, pack_w(wa));
        release_out("desc");

        wa = '{7, 7, 7, 7, 7, 7, 7, 7};
        run_job(32'h89ABCDEF, pack_w(wa), 1'b0, EQ_LAT, "equal");
        check("equal_char", out_character, 32'h89ABCDEF);
        release_out("equal");

        run_job(c0, wrev, 1'b0, MIX_LAT, "rev");
        check("rev_char", out_character, 32'h01234567);
        wa = '{0, 1, 2, 3, 4, 5, 6, 7};
        check("rev_weight", out_weight, pack_w(wa));
        release_out("rev");

        wa = '{0, 31, 0, 31, 16, 16, 1, 30};
        run_job(32'hFEDCBA98, pack_w(wa), 1'b1, MIX_LAT, "ext");
        check("ext_char", out_character, 32'hA8EDCFB9);
        release_out("ext");

        run_job(c0, w0, 1'b0, MIX_LAT, "bp");
        in_character = 32'h01234567;
        in_weight    = wrev;
        in_desc      = 1'b0;
        in_valid     = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1'b1);
            check("bp_hold_ready", in_ready, 1'b0);
            check("bp_hold_char", out_character, 32'h74206135);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("bp_exit_ready", in_ready, 1'b1);
        check("bp_exit_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_accept", in_ready, 1'b0);
        model_sort(32'h01234567, wrev, 1'b0, exp_c, exp_w);
        wait_valid(MIX_LAT, "bp2");
        check("bp2_char", out_character, 32'h76543210);
        release_out("bp2");

        wait_ready();
        in_character = 32'h13572468;
        in_weight    = w0;
        in_desc      = 1'b0;
        in_valid     = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        model_valid = 1'b0;
        #1;
        check("abort_valid", out_valid, 1'b0);
        check("abort_ready", in_ready, 1'b1);
        check("abort_char", out_character, '0);
        check("abort_weight", out_weight, '0);
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("abort_no_accept", in_ready, 1'b1);
        check("abort_char_hold", out_character, '0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("abort_idle", in_ready, 1'b1);

        run_job(c0, w0, 1'b1, MIX_LAT, "post");
        check("post_char", out_character, 32'h53612047);
        release_out("post");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
